// File: rtl/rom_port_arbiter_pkg.sv
// Shared encodings and the address-check helper for the ROM port arbiter.
package rom_port_arbiter_pkg;

  // Transaction FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Owner flag encodings
  localparam logic OWN_INSN = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Read data returned with a faulted access
  localparam logic [31:0] FAULT_RDATA = 32'h0000_0000;

  // Access fault: misaligned, below the window, at/above its end (33-bit compare
  // so the window end never wraps), or any store attempt.
  function automatic logic addr_fault(input logic [31:0]   addr,
                                      input logic          we,
                                      input logic [31:0]   base,
                                      input int unsigned   depth);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(depth) << 2);
    return (addr[1:0] != 2'b00) || (a < lo) || (a >= hi) || we;
  endfunction

endpackage

// File: rtl/rom_arb_grant.sv
// Grant select between fetch and data requesters with fetch starvation guard.
module rom_arb_grant
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic insn_valid_i,
  input  logic data_valid_i,
  input  logic idle_i,
  output logic grant_insn_o,
  output logic grant_data_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt_q;
  logic          starved;

  assign starved = (starve_cnt_q == CW'(STARVE_LIMIT));

  // Data has priority unless fetch has waited through STARVE_LIMIT data grants
  always_comb begin
    grant_insn_o = idle_i && insn_valid_i && (!data_valid_i || starved);
    grant_data_o = idle_i && data_valid_i && !(insn_valid_i && starved);
  end

  // Count data grants taken while fetch is waiting; saturate at the limit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else if (idle_i) begin
      if (grant_insn_o || !insn_valid_i) begin
        starve_cnt_q <= '0;
      end else if (grant_data_o && !starved) begin
        starve_cnt_q <= starve_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the synchronous ROM read port between instruction fetch and data loads.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP, faults skip to RESP.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_DEPTH    = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int         AW           = $clog2(MEM_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          insn_req_valid_i,
  input  logic [31:0]   insn_req_addr_i,
  output logic          insn_req_ready_o,
  output logic          insn_rsp_valid_o,
  input  logic          insn_rsp_ready_i,
  output logic [31:0]   insn_rsp_rdata_o,
  output logic          insn_rsp_err_o,
  input  logic          data_req_valid_i,
  input  logic [31:0]   data_req_addr_i,
  input  logic          data_req_we_i,
  output logic          data_req_ready_o,
  output logic          data_rsp_valid_o,
  input  logic          data_rsp_ready_i,
  output logic [31:0]   data_rsp_rdata_o,
  output logic          data_rsp_err_o,
  output logic          rom_en_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic [31:0]   rom_rdata_i
);

  logic [1:0]    state_q;
  logic          owner_q;
  logic [AW-1:0] rom_addr_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          idle;
  logic          grant_insn;
  logic          grant_data;
  logic [31:0]   sel_addr;
  logic          sel_we;
  logic          sel_fault;
  logic [AW-1:0] sel_word;
  logic          owner_rsp_ready;
  logic          rsp_active;

  assign idle = (state_q == ST_IDLE);

  rom_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .insn_valid_i (insn_req_valid_i),
    .data_valid_i (data_req_valid_i),
    .idle_i       (idle),
    .grant_insn_o (grant_insn),
    .grant_data_o (grant_data)
  );

  // Decode the granted request: byte address, fault and ROM word index
  always_comb begin
    sel_addr  = grant_data ? data_req_addr_i : insn_req_addr_i;
    sel_we    = grant_data && data_req_we_i;
    sel_fault = addr_fault(sel_addr, sel_we, BASE_ADDR, MEM_DEPTH);
    sel_word  = AW'((sel_addr - BASE_ADDR) >> 2);
  end

  assign owner_rsp_ready = (owner_q == OWN_DATA) ? data_rsp_ready_i : insn_rsp_ready_i;

  // Transaction FSM with owner, address, fault and read-data latches
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_INSN;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_insn || grant_data) begin
            owner_q <= grant_data ? OWN_DATA : OWN_INSN;
            err_q   <= sel_fault;
            if (sel_fault) begin
              rdata_q <= FAULT_RDATA;
              state_q <= ST_RESP;
            end else begin
              rom_addr_q <= sel_word;
              state_q    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          rdata_q <= rom_rdata_i;
          state_q <= ST_RESP;
        end
        default: begin
          if (owner_rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Route ready/response to the owning requester; the other side stays 0
  always_comb begin
    rsp_active       = (state_q == ST_RESP);
    insn_req_ready_o = grant_insn;
    data_req_ready_o = grant_data;
    insn_rsp_valid_o = rsp_active && (owner_q == OWN_INSN);
    data_rsp_valid_o = rsp_active && (owner_q == OWN_DATA);
    insn_rsp_rdata_o = insn_rsp_valid_o ? rdata_q : 32'h0;
    data_rsp_rdata_o = data_rsp_valid_o ? rdata_q : 32'h0;
    insn_rsp_err_o   = insn_rsp_valid_o && err_q;
    data_rsp_err_o   = data_rsp_valid_o && err_q;
    rom_en_o         = (state_q == ST_ISSUE);
    rom_addr_o       = rom_addr_q;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a scoreboard of expected responses.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        insn_req_valid, insn_req_ready, insn_rsp_valid, insn_rsp_ready, insn_rsp_err;
  logic [31:0] insn_req_addr, insn_rsp_rdata;
  logic        data_req_valid, data_req_we, data_req_ready, data_rsp_valid, data_rsp_ready, data_rsp_err;
  logic [31:0] data_req_addr, data_rsp_rdata;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_rdata;

  logic [31:0] mem [256];

  typedef struct {
    bit          own_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rom_pulses = 0;
  int          rsp_seen = 0;
  int          gcount = 0;
  logic [9:0]  glog = '0;
  logic [7:0]  exp_rom_addr = '0;

  always #5 clk = ~clk;

  rom_port_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .insn_req_valid_i (insn_req_valid),
    .insn_req_addr_i  (insn_req_addr),
    .insn_req_ready_o (insn_req_ready),
    .insn_rsp_valid_o (insn_rsp_valid),
    .insn_rsp_ready_i (insn_rsp_ready),
    .insn_rsp_rdata_o (insn_rsp_rdata),
    .insn_rsp_err_o   (insn_rsp_err),
    .data_req_valid_i (data_req_valid),
    .data_req_addr_i  (data_req_addr),
    .data_req_we_i    (data_req_we),
    .data_req_ready_o (data_req_ready),
    .data_rsp_valid_o (data_rsp_valid),
    .data_rsp_ready_i (data_rsp_ready),
    .data_rsp_rdata_o (data_rsp_rdata),
    .data_rsp_err_o   (data_rsp_err),
    .rom_en_o         (rom_en),
    .rom_addr_o       (rom_addr),
    .rom_rdata_i      (rom_rdata)
  );

  // Synchronous ROM model
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
    mem[4] = 32'hDEAD_BEEF;
    rom_rdata = '0;
    forever begin
      @(posedge clk);
      if (rom_en) rom_rdata <= mem[rom_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic note_grant(input bit is_data, input logic [31:0] addr, input logic we);
    exp_t       e;
    logic [7:0] word;
    bit         fault;
    fault = (addr[1:0] != 2'b00) || (addr >= 32'd1024) || (is_data && we);
    word  = addr[9:2];
    e.own_data = is_data;
    e.err      = fault;
    e.rdata    = fault ? 32'h0 : mem[word];
    sb.push_back(e);
    if (!fault) exp_rom_addr = word;
    if (gcount < 10) glog[9 - gcount] = is_data;
    gcount++;
  endtask

  task automatic pop_check(input bit is_data);
    exp_t e;
    if (sb.size() == 0) begin
      check("rsp_unexpected", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("rsp_owner", 32'(is_data), 32'(e.own_data));
      check("rsp_rdata", is_data ? data_rsp_rdata : insn_rsp_rdata, e.rdata);
      check("rsp_err", 32'(is_data ? data_rsp_err : insn_rsp_err), 32'(e.err));
      check("rsp_other_valid", 32'(is_data ? insn_rsp_valid : data_rsp_valid), 32'd0);
    end
  endtask

  // Monitor: sampled on the falling edge, between active edges
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (insn_req_valid && insn_req_ready) note_grant(1'b0, insn_req_addr, 1'b0);
        if (data_req_valid && data_req_ready) note_grant(1'b1, data_req_addr, data_req_we);
        if (rom_en) begin
          rom_pulses++;
          check("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
        end
        if (insn_rsp_valid || data_rsp_valid) rsp_seen++;
        if (insn_rsp_valid && insn_rsp_ready) pop_check(1'b0);
        if (data_rsp_valid && data_rsp_ready) pop_check(1'b1);
      end
    end
  end

  // Present a request and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic issue(input bit is_data, input logic [31:0] addr, input logic we);
    bit got = 0;
    if (is_data) begin
      data_req_valid = 1'b1; data_req_addr = addr; data_req_we = we;
    end else begin
      insn_req_valid = 1'b1; insn_req_addr = addr;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_data ? data_req_ready : insn_req_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (is_data) begin
      data_req_valid = 1'b0; data_req_we = 1'b0;
    end else begin
      insn_req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) check(tag, 32'(sb.size()), 32'd0);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'({insn_req_ready, data_req_ready}), 32'd0);
    check({tag, "_rsp_valid"}, 32'({insn_rsp_valid, data_rsp_valid}), 32'd0);
    check({tag, "_err"}, 32'({insn_rsp_err, data_rsp_err}), 32'd0);
    check({tag, "_insn_rdata"}, insn_rsp_rdata, 32'd0);
    check({tag, "_data_rdata"}, data_rsp_rdata, 32'd0);
    check({tag, "_rom"}, 32'({rom_en, rom_addr}), 32'd0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses0;
    int seen0;
    bit got;
    logic [31:0] held;
    rst = 1'b1;
    insn_req_valid = 1'b0; insn_req_addr = '0; insn_rsp_ready = 1'b1;
    data_req_valid = 1'b0; data_req_addr = '0; data_req_we = 1'b0; data_rsp_ready = 1'b1;

    // Reset for 3 cycles
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Fetch of word 4 with exact latency
    @(posedge clk); #1;
    pulses0 = rom_pulses;
    issue(1'b0, 32'h0000_0010, 1'b0);
    @(negedge clk);
    check("fetch_e0_rom_en", 32'(rom_en), 32'd1);
    check("fetch_e0_rom_addr", 32'(rom_addr), 32'd4);
    check("fetch_e0_valid", 32'(insn_rsp_valid), 32'd0);
    @(negedge clk);
    check("fetch_e1_rom_en", 32'(rom_en), 32'd0);
    check("fetch_e1_valid", 32'(insn_rsp_valid), 32'd0);
    @(negedge clk);
    check("fetch_e2_valid", 32'(insn_rsp_valid), 32'd1);
    check("fetch_e2_rdata", insn_rsp_rdata, 32'hDEAD_BEEF);
    check("fetch_e2_err", 32'(insn_rsp_err), 32'd0);
    @(negedge clk);
    check("fetch_e3_valid", 32'(insn_rsp_valid), 32'd0);
    wait_idle("fetch_drain");
    check("fetch_rom_pulses", 32'(rom_pulses - pulses0), 32'd1);

    // Faulting accesses: no ROM access, response right after acceptance
    pulses0 = rom_pulses;
    issue(1'b1, 32'h0000_0002, 1'b0);
    @(negedge clk);
    check("fault_misalign_valid", 32'(data_rsp_valid), 32'd1);
    check("fault_misalign_err", 32'(data_rsp_err), 32'd1);
    check("fault_misalign_rdata", data_rsp_rdata, 32'd0);
    wait_idle("fault_misalign_drain");
    issue(1'b1, 32'h0000_0000, 1'b1);
    @(negedge clk);
    check("fault_store_valid", 32'(data_rsp_valid), 32'd1);
    check("fault_store_err", 32'(data_rsp_err), 32'd1);
    wait_idle("fault_store_drain");
    issue(1'b0, 32'h0000_0400, 1'b0);
    @(negedge clk);
    check("fault_range_valid", 32'(insn_rsp_valid), 32'd1);
    check("fault_range_err", 32'(insn_rsp_err), 32'd1);
    check("fault_range_rdata", insn_rsp_rdata, 32'd0);
    wait_idle("fault_range_drain");
    check("fault_rom_pulses", 32'(rom_pulses - pulses0), 32'd0);

    // Last in-range word
    issue(1'b1, 32'h0000_03FC, 1'b0);
    wait_idle("last_word_drain");

    // Response backpressure with a competing fetch pending
    data_rsp_ready = 1'b0;
    issue(1'b1, 32'h0000_0008, 1'b0);
    insn_req_valid = 1'b1; insn_req_addr = 32'h0000_0020;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_rsp_valid) begin
        got = 1;
        break;
      end
    end
    check("bp_valid_seen", 32'(got), 32'd1);
    held = data_rsp_rdata;
    check("bp_rdata", held, mem[2]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(data_rsp_valid), 32'd1);
      check("bp_hold_rdata", data_rsp_rdata, held);
      check("bp_no_grant", 32'({insn_req_ready, rom_en}), 32'd0);
    end
    @(posedge clk); #1;
    data_rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (insn_req_ready) begin
        got = 1;
        break;
      end
    end
    check("bp_fetch_granted", 32'(got), 32'd1);
    @(posedge clk); #1;
    insn_req_valid = 1'b0;
    wait_idle("bp_drain");

    // Starvation guard with both requesters continuously valid
    gcount = 0;
    glog = '0;
    insn_req_valid = 1'b1; insn_req_addr = 32'h0000_0004;
    data_req_valid = 1'b1; data_req_addr = 32'h0000_0030; data_req_we = 1'b0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (gcount >= 10) begin
        got = 1;
        break;
      end
    end
    #1;
    insn_req_valid = 1'b0;
    data_req_valid = 1'b0;
    check("starve_done", 32'(got), 32'd1);
    check("starve_order", 32'(glog), 32'(10'b1111011110));
    wait_idle("starve_drain");

    // Asynchronous reset during WAIT drops the transaction
    issue(1'b1, 32'h0000_000C, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    sb.delete();
    seen0 = rsp_seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_seen - seen0), 32'd0);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
